// File: rtl/sevseg_scanner.sv
// Multiplexed seven-segment scanner with per-digit blanking, decimal points, PWM
// brightness, a guard cycle at each slot start and frame-synchronous value updates.
module sevseg_scanner #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 4096,
    parameter int PWM_BITS        = 3,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit SEL_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dot_en,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     select,
    output logic                  frame_start
);
    localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int THR_W = CNT_W + 1;
    localparam int STEP  = TICKS_PER_DIGIT / (2 ** PWM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   shadow_dot_q, shadow_dot_d, disp_dot_q, disp_dot_d;
    logic [DIGITS-1:0]   shadow_en_q, shadow_en_d, disp_en_q, disp_en_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                fs_q, fs_d;

    logic                slot_end, frame_end, lit, cur_en;
    logic [3:0]          cur_nib;
    logic [THR_W-1:0]    thr;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   sel_on;

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        pending_d    = pending_q;
        shadow_val_d = shadow_val_q;
        shadow_dot_d = shadow_dot_q;
        shadow_en_d  = shadow_en_q;
        disp_val_d   = disp_val_q;
        disp_dot_d   = disp_dot_q;
        disp_en_d    = disp_en_q;
        // Copy uses the pre-write shadow, so a write on the boundary cycle waits a frame.
        if (frame_end && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dot_d = shadow_dot_q;
            disp_en_d  = shadow_en_q;
            pending_d  = 1'b0;
        end
        if (wr) begin
            shadow_val_d = value;
            shadow_dot_d = dot_en;
            shadow_en_d  = digit_en;
            pending_d    = 1'b1;
        end

        cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];
        cur_en  = disp_en_q[idx_q];
        thr     = (THR_W'(brightness) + THR_W'(1)) * THR_W'(STEP);
        // cnt==0 is the anti-ghosting guard cycle.
        lit     = cur_en && (cnt_q != '0) && ({1'b0, cnt_q} < thr);

        seg_on  = cur_en ? hex7(cur_nib) : 7'h00;
        seg_d   = seg_on ^ {7{SEG_ACTIVE_LOW}};
        dp_d    = (cur_en && disp_dot_q[idx_q]) ^ SEG_ACTIVE_LOW;
        sel_on  = '0;
        if (lit)
            sel_on[idx_q] = 1'b1;
        sel_d   = sel_on ^ {DIGITS{SEL_ACTIVE_LOW}};
        fs_d    = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            shadow_val_q <= '0;
            shadow_dot_q <= '0;
            shadow_en_q  <= '0;
            disp_val_q   <= '0;
            disp_dot_q   <= '0;
            disp_en_q    <= '0;
            seg_q        <= {7{SEG_ACTIVE_LOW}};
            dp_q         <= SEG_ACTIVE_LOW;
            sel_q        <= {DIGITS{SEL_ACTIVE_LOW}};
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_val_q <= shadow_val_d;
            shadow_dot_q <= shadow_dot_d;
            shadow_en_q  <= shadow_en_d;
            disp_val_q   <= disp_val_d;
            disp_dot_q   <= disp_dot_d;
            disp_en_q    <= disp_en_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            fs_q         <= fs_d;
        end
    end

    assign segments    = seg_q;
    assign dp          = dp_q;
    assign select      = sel_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_sevseg_scanner.sv
// Bench for sevseg_scanner: vector table, hand sequences for frame-sync corners,
// and a randomized run against an arithmetic reference model.
module tb_sevseg_scanner;
    localparam int D = 4, T = 8, P = 2, STEP = 2, FR = D * T;

    logic        clk, rst, wr;
    logic [15:0] value;
    logic [3:0]  dot_en, digit_en;
    logic [1:0]  brightness;
    logic [6:0]  segments;
    logic        dp, frame_start;
    logic [3:0]  select;

    sevseg_scanner #(.DIGITS(D), .TICKS_PER_DIGIT(T), .PWM_BITS(P),
                     .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .wr(wr), .value(value), .dot_en(dot_en),
        .digit_en(digit_en), .brightness(brightness), .segments(segments),
        .dp(dp), .select(select), .frame_start(frame_start));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int errors = 0, checks = 0;

    // Reference model: position in the frame comes from a plain tick count since reset.
    int unsigned t;
    bit          pend;
    logic [15:0] sh_v, d_v;
    logic [3:0]  sh_dot, sh_en, d_dot, d_en;
    logic [3:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always @(posedge clk) begin : model
        int c, i;
        if (rst) begin
            t = 0; pend = 0;
            sh_v = '0; sh_dot = '0; sh_en = '0; d_v = '0; d_dot = '0; d_en = '0;
            e_sel = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            c = int'(t % T);
            i = int'((t / T) % D);
            e_fs  = (t % FR) == 0;
            e_seg = d_en[i] ? ~HEX[d_v[i*4 +: 4]] : 7'h7F;
            e_dp  = d_en[i] ? ~d_dot[i] : 1'b1;
            e_sel = (d_en[i] && c != 0 && c < (int'(brightness) + 1) * STEP) ? ~(4'b0001 << i) : 4'hF;
            if ((t % FR) == FR - 1 && pend) begin
                d_v = sh_v; d_dot = sh_dot; d_en = sh_en; pend = 0;
            end
            if (wr) begin
                sh_v = value; sh_dot = dot_en; sh_en = digit_en; pend = 1;
            end
            t++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dt);
        wr = 1'b1; value = v; digit_en = en; dot_en = dt;
        tick();
        wr = 1'b0;
    endtask

    task automatic sync_fs();
        int n;
        n = 0;
        tick();
        while (!frame_start && n < 100) begin
            tick();
            n++;
        end
        if (!frame_start) chk("fs_timeout", 0, 1);
    endtask

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0]      den;
        logic [3:0]      dot;
        logic [1:0]      br;
        logic [3:0][6:0] seg;
        logic [3:0][3:0] lit;
        logic [3:0]      dpx;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] sa [32];
    logic [6:0] sg [32];
    logic       dpa [32];

    task automatic capture_frame();
        for (int k = 0; k < FR; k++) begin
            sa[k] = select; sg[k] = segments; dpa[k] = dp;
            tick();
        end
    endtask

    initial begin
        int fs_cnt, fs_first, fs_gap_bad, last_fs, bad_sel, bad_seg, nlit, stray, n_ab, n_b;
        rst = 1'b1; wr = 1'b0; value = '0; dot_en = '0; digit_en = '0; brightness = 2'd3;

        vecs[0] = '{16'h4321, 4'hF, 4'h0, 2'd3, {7'h19, 7'h30, 7'h24, 7'h79}, {4'd7, 4'd7, 4'd7, 4'd7}, 4'b1111};
        vecs[1] = '{16'h4321, 4'hF, 4'h0, 2'd0, {7'h19, 7'h30, 7'h24, 7'h79}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'b1111};
        vecs[2] = '{16'h4321, 4'hF, 4'h0, 2'd1, {7'h19, 7'h30, 7'h24, 7'h79}, {4'd3, 4'd3, 4'd3, 4'd3}, 4'b1111};
        vecs[3] = '{16'h8765, 4'b0101, 4'b0001, 2'd3, {7'h7F, 7'h78, 7'h7F, 7'h12}, {4'd0, 4'd7, 4'd0, 4'd7}, 4'b1110};
        vecs[4] = '{16'hFEDC, 4'hF, 4'b1010, 2'd2, {7'h0E, 7'h06, 7'h21, 7'h46}, {4'd5, 4'd5, 4'd5, 4'd5}, 4'b0101};

        // Reset state, then 70 blank cycles with frame_start every 32.
        repeat (3) tick();
        chk("rst_sel", select, 4'hF);
        chk("rst_seg", segments, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fs", frame_start, 1'b0);
        rst = 1'b0;
        tick();
        fs_cnt = 0; fs_first = -1; fs_gap_bad = 0; last_fs = -1; bad_sel = 0; bad_seg = 0;
        for (int k = 0; k < 70; k++) begin
            if (select !== 4'hF) bad_sel++;
            if (segments !== 7'h7F) bad_seg++;
            if (frame_start) begin
                if (fs_first < 0) fs_first = k;
                if (last_fs >= 0 && k - last_fs != FR) fs_gap_bad++;
                last_fs = k;
                fs_cnt++;
            end
            tick();
        end
        chk("blank_sel", bad_sel, 0);
        chk("blank_seg", bad_seg, 0);
        chk("fs_first", fs_first, 0);
        chk("fs_count", fs_cnt, 3);
        chk("fs_period", fs_gap_bad, 0);

        // Vector table: one full frame captured per entry.
        foreach (vecs[v]) begin
            brightness = vecs[v].br;
            do_wr(vecs[v].val, vecs[v].den, vecs[v].dot);
            sync_fs();
            sync_fs();
            capture_frame();
            for (int s = 0; s < D; s++) begin
                nlit = 0; stray = 0;
                for (int c = 0; c < T; c++) begin
                    if (sa[s*T+c] == ~(4'b0001 << s)) nlit++;
                    else if (sa[s*T+c] != 4'hF) stray++;
                end
                chk($sformatf("v%0d_seg%0d", v, s), sg[s*T+1], vecs[v].seg[s]);
                chk($sformatf("v%0d_dp%0d", v, s), dpa[s*T+1], vecs[v].dpx[s]);
                chk($sformatf("v%0d_lit%0d", v, s), nlit, vecs[v].lit[s]);
                chk($sformatf("v%0d_stray%0d", v, s), stray, 0);
            end
        end

        // Two writes in one frame: current frame untouched, next frame all 'b'.
        sync_fs();
        repeat (3) tick();
        do_wr(16'hAAAA, 4'hF, 4'h0);
        repeat (4) tick();
        do_wr(16'hBBBB, 4'hF, 4'h0);
        n_ab = 0;
        for (int k = 0; k < 40 && !frame_start; k++) begin
            if (segments == 7'h08 || segments == 7'h03) n_ab++;
            tick();
        end
        chk("midframe_unchanged", n_ab, 0);
        chk("midframe_fs_seen", frame_start, 1'b1);
        capture_frame();
        n_b = 0;
        for (int k = 0; k < FR; k++) if (sg[k] == 7'h03) n_b++;
        chk("last_write_wins", n_b, FR);

        // Write landing on the boundary cycle waits one more frame.
        sync_fs();
        repeat (30) tick();
        do_wr(16'h1111, 4'hF, 4'h0);
        chk("bnd_fs", frame_start, 1'b0);
        tick();
        tick();
        chk("bnd_old_frame", segments, 7'h03);
        sync_fs();
        tick();
        chk("bnd_new_frame", segments, 7'h79);

        // Reset mid-frame with a write pending: blank now and afterwards.
        do_wr(16'h2222, 4'hF, 4'hF);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mrst_sel", select, 4'hF);
        chk("mrst_seg", segments, 7'h7F);
        chk("mrst_dp", dp, 1'b1);
        chk("mrst_fs", frame_start, 1'b0);
        rst = 1'b0;
        bad_sel = 0; bad_seg = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (select !== 4'hF) bad_sel++;
            if (segments !== 7'h7F) bad_seg++;
        end
        chk("mrst_lost_sel", bad_sel, 0);
        chk("mrst_lost_seg", bad_seg, 0);

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            wr  = ($urandom_range(0, 15) == 0);
            value = 16'($urandom);
            dot_en = 4'($urandom);
            digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
            tick();
            chk("rnd_sel", select, e_sel);
            chk("rnd_seg", segments, e_seg);
            chk("rnd_dp", dp, e_dp);
            chk("rnd_fs", frame_start, e_fs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
